// File: rtl/vram_pkg.sv
// Shared constants and types for the display-buffer write path.
// Geometry, opcode encodings, RGB565 pixel layout and the writer FSM states.
package vram_pkg;
    localparam int H_RES    = 400;
    localparam int V_RES    = 240;
    localparam int FB_WORDS = H_RES * V_RES;
    localparam int AW       = 17;
    localparam int CW       = 16;
    localparam int XW       = 9;
    localparam int YW       = 8;

    localparam logic OP_PLOT = 1'b0;
    localparam logic OP_FILL = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/vram_rect_walker.sv
// Rectangle walker: col/row/row_base/address counters for a clipped fill.
// Latency: address valid the cycle after load; advances one pixel per advance pulse.
// Backpressure: all state holds while advance is low.
module vram_rect_walker
    import vram_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          advance,
    input  logic [XW-1:0] x0,
    input  logic [AW-1:0] row_base,
    input  logic [XW-1:0] w_last,
    input  logic [YW-1:0] h_last,
    output logic [AW-1:0] addr,
    output logic          last
);
    logic [XW-1:0] x0_q, x0_d, w_last_q, w_last_d, col_q, col_d;
    logic [YW-1:0] h_last_q, h_last_d, row_q, row_d;
    logic [AW-1:0] row_base_q, row_base_d, addr_q, addr_d;

    always_comb begin
        x0_d       = x0_q;
        w_last_d   = w_last_q;
        h_last_d   = h_last_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        if (load) begin
            x0_d       = x0;
            w_last_d   = w_last;
            h_last_d   = h_last;
            col_d      = '0;
            row_d      = '0;
            row_base_d = row_base;
            addr_d     = row_base + AW'(x0);
        end else if (advance) begin
            if (col_q != w_last_q) begin
                col_d  = col_q + XW'(1);
                addr_d = addr_q + AW'(1);
            end else if (row_q != h_last_q) begin
                // Next row restarts from the rectangle's left edge, not the line start.
                col_d      = '0;
                row_d      = row_q + YW'(1);
                row_base_d = row_base_q + AW'(H_RES);
                addr_d     = row_base_q + AW'(H_RES) + AW'(x0_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q       <= '0;
            w_last_q   <= '0;
            h_last_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            x0_q       <= x0_d;
            w_last_q   <= w_last_d;
            h_last_q   <= h_last_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

    assign addr = addr_q;
    assign last = (col_q == w_last_q) && (row_q == h_last_q);
endmodule

// File: rtl/vram_rect_writer.sv
// PLOT/FILL command agent writing clipped rectangles into the display buffer RAM.
// Latency: first write the cycle after accept; w*h granted cycles per command.
// Backpressure: one command in flight (READY only in IDLE); walker stalls when grant is low.
module vram_rect_writer
    import vram_pkg::*;
(
    input  logic          iACLK,
    input  logic          iRST,
    input  logic          iCMD_VALID,
    output logic          oCMD_READY,
    input  logic          iCMD_OP,
    input  logic [XW-1:0] iCMD_X,
    input  logic [YW-1:0] iCMD_Y,
    input  logic [XW-1:0] iCMD_W,
    input  logic [YW-1:0] iCMD_H,
    input  logic [CW-1:0] iCMD_COLOR,
    input  logic          iVRAM_GRANT,
    output logic [AW-1:0] oVRAM_ADDR,
    output logic [CW-1:0] oVRAM_WDATA,
    output logic          oVRAM_WRITE,
    output logic [1:0]    oVRAM_BE,
    output logic          oBUSY,
    output logic          oERR
);
    state_t        state_q, state_d;
    rgb565_t       colour_q, colour_d;
    logic          err_q, err_d;
    logic          accept, cmd_ok, load, last;
    logic [9:0]    w_req, h_req, w_eff, h_eff;
    logic [XW-1:0] w_last;
    logic [YW-1:0] h_last;
    logic [AW-1:0] row_base;

    // Validation and clipping in 10-bit arithmetic so H_RES-X never wraps.
    always_comb begin
        accept   = iCMD_VALID && oCMD_READY;
        cmd_ok   = ({1'b0, iCMD_X} < 10'(H_RES)) && ({2'b0, iCMD_Y} < 10'(V_RES)) &&
                   ((iCMD_OP == OP_PLOT) || ((iCMD_W != '0) && (iCMD_H != '0)));
        load     = accept && cmd_ok;
        w_req    = (iCMD_OP == OP_PLOT) ? 10'd1 : {1'b0, iCMD_W};
        h_req    = (iCMD_OP == OP_PLOT) ? 10'd1 : {2'b0, iCMD_H};
        w_eff    = min10(w_req, 10'(H_RES) - {1'b0, iCMD_X});
        h_eff    = min10(h_req, 10'(V_RES) - {2'b0, iCMD_Y});
        w_last   = XW'(w_eff - 10'd1);
        h_last   = YW'(h_eff - 10'd1);
        row_base = AW'(iCMD_Y) * AW'(H_RES);
        colour_d = load ? rgb565_t'(iCMD_COLOR) : colour_q;
        err_d    = accept && !cmd_ok;
    end

    always_ff @(posedge iACLK) begin
        if (iRST) begin
            state_q  <= ST_IDLE;
            colour_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            colour_q <= colour_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load) state_d = ST_RUN;
            ST_RUN:  if (oVRAM_WRITE && last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        oCMD_READY  = (state_q == ST_IDLE);
        oBUSY       = (state_q == ST_RUN);
        oVRAM_WRITE = (state_q == ST_RUN) && iVRAM_GRANT && !iRST;
        oVRAM_BE    = 2'b11;
        oVRAM_WDATA = colour_q;
        oERR        = err_q;
    end

    vram_rect_walker u_walker (
        .clk      (iACLK),
        .rst      (iRST),
        .load     (load),
        .advance  (oVRAM_WRITE),
        .x0       (iCMD_X),
        .row_base (row_base),
        .w_last   (w_last),
        .h_last   (h_last),
        .addr     (oVRAM_ADDR),
        .last     (last)
    );
endmodule
